// File: rtl/sevenseg_if.sv
// Seven-segment capture bus: display-side pins in, recovered digit data and pulses out.
interface sevenseg_if #(
   parameter int unsigned NUM_DIGITS = 4
) ();
   logic [6:0]              seg_n;
   logic [NUM_DIGITS-1:0]   dig_sel_n;
   logic                    clr;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]   digit_valid;
   logic [NUM_DIGITS-1:0]   blank;
   logic                    cap_stb;
   logic                    illegal;
   logic                    sel_err;
   logic                    frame_done;

   // Drives the display pins and clear; observes recovered data.
   modport master (
      output seg_n, dig_sel_n, clr,
      input  digits, digit_valid, blank, cap_stb, illegal, sel_err, frame_done
   );

   // The capture block itself.
   modport slave (
      input  seg_n, dig_sel_n, clr,
      output digits, digit_valid, blank, cap_stb, illegal, sel_err, frame_done
   );
endinterface

// File: rtl/sevenseg_capture.sv
// Recovers hex digit values from a multiplexed, active-low seven-segment bus.
module sevenseg_capture #(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned STABLE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   sevenseg_if.slave  bus
);

   localparam int unsigned SW    = 7 + NUM_DIGITS;
   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [NUM_DIGITS-1:0] ALL_DIGITS = {NUM_DIGITS{1'b1}};

   typedef enum logic [1:0] {
      SETTLE  = 2'd0,
      CAPTURE = 2'd1,
      HOLD    = 2'd2
   } state_t;

   state_t state_q, state_nxt;

   logic [SW-1:0]    sync1_q, sync2_q, prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_nxt_c;
   logic             change_c;
   logic             capture_c;

   logic [6:0]              seg_c;
   logic [NUM_DIGITS-1:0]   sel_c;
   logic                    sel_any_c, sel_multi_c;
   logic                    dec_legal_c;
   logic [3:0]              dec_val_c;

   logic [4*NUM_DIGITS-1:0] digits_q, digits_nxt;
   logic [NUM_DIGITS-1:0]   valid_q, valid_nxt;
   logic [NUM_DIGITS-1:0]   blank_q, blank_nxt;
   logic [NUM_DIGITS-1:0]   mask_q, mask_nxt;
   logic                    stb_q, stb_nxt;
   logic                    ill_q, ill_nxt;
   logic                    selerr_q, selerr_nxt;
   logic                    fd_q, fd_nxt;

   // Pattern lookup: returns {legal, value}.
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'h3F:   decode = 5'h10;
         7'h06:   decode = 5'h11;
         7'h5B:   decode = 5'h12;
         7'h4F:   decode = 5'h13;
         7'h66:   decode = 5'h14;
         7'h6D:   decode = 5'h15;
         7'h7D:   decode = 5'h16;
         7'h07:   decode = 5'h17;
         7'h7F:   decode = 5'h18;
         7'h6F:   decode = 5'h19;
         7'h77:   decode = 5'h1A;
         7'h7C:   decode = 5'h1B;
         7'h39:   decode = 5'h1C;
         7'h5E:   decode = 5'h1D;
         7'h79:   decode = 5'h1E;
         7'h71:   decode = 5'h1F;
         default: decode = 5'h00;
      endcase
   endfunction

   // Two-stage synchroniser (stored active-high) plus previous-sample register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= ~{bus.dig_sel_n, bus.seg_n};
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Stability counter: restarts on any change, saturates at the threshold.
   always_comb begin
      change_c  = (sync2_q != prev_q);
      cnt_nxt_c = cnt_q;
      if (change_c)
         cnt_nxt_c = '0;
      else if (cnt_q != CNT_MAX)
         cnt_nxt_c = cnt_q + CNT_W'(1);
   end

   // Counter and FSM state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         state_q <= SETTLE;
      end else begin
         cnt_q   <= cnt_nxt_c;
         state_q <= state_nxt;
      end
   end

   // Next state: one CAPTURE per stable window; any change restarts settling.
   always_comb begin
      state_nxt = state_q;
      capture_c = 1'b0;
      case (state_q)
         SETTLE:  if (cnt_nxt_c == CNT_MAX) state_nxt = CAPTURE;
         CAPTURE: begin
            capture_c = 1'b1;
            state_nxt = HOLD;
         end
         HOLD:    state_nxt = HOLD;
         default: state_nxt = SETTLE;
      endcase
      if (change_c)
         state_nxt = SETTLE;
   end

   // Classify the stable sample; prev_q holds the window value during CAPTURE.
   always_comb begin
      seg_c       = prev_q[6:0];
      sel_c       = prev_q[SW-1:7];
      sel_any_c   = |sel_c;
      sel_multi_c = |(sel_c & (sel_c - NUM_DIGITS'(1)));
      {dec_legal_c, dec_val_c} = decode(seg_c);
   end

   // Capture update, frame tracking and clear (clear wins over data, not pulses).
   always_comb begin
      digits_nxt = digits_q;
      valid_nxt  = valid_q;
      blank_nxt  = blank_q;
      mask_nxt   = mask_q;
      stb_nxt    = 1'b0;
      ill_nxt    = 1'b0;
      selerr_nxt = 1'b0;
      fd_nxt     = 1'b0;

      if (mask_q == ALL_DIGITS) begin
         fd_nxt   = 1'b1;
         mask_nxt = '0;
      end

      if (capture_c && sel_any_c) begin
         stb_nxt = 1'b1;
         if (sel_multi_c)
            selerr_nxt = 1'b1;
         else if (!dec_legal_c && (seg_c != 7'h00))
            ill_nxt = 1'b1;
      end

      if (capture_c && sel_any_c && !sel_multi_c) begin
         for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (sel_c[i]) begin
               if (dec_legal_c) begin
                  digits_nxt[4*i +: 4] = dec_val_c;
                  valid_nxt[i] = 1'b1;
                  blank_nxt[i] = 1'b0;
                  mask_nxt[i]  = 1'b1;
               end else if (seg_c == 7'h00) begin
                  valid_nxt[i] = 1'b0;
                  blank_nxt[i] = 1'b1;
                  mask_nxt[i]  = 1'b1;
               end else begin
                  valid_nxt[i] = 1'b0;
                  blank_nxt[i] = 1'b0;
               end
            end
         end
      end

      if (bus.clr) begin
         digits_nxt = '0;
         valid_nxt  = '0;
         blank_nxt  = '0;
         mask_nxt   = '0;
         fd_nxt     = 1'b0;
      end
   end

   // Output and frame-mask registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits_q <= '0;
         valid_q  <= '0;
         blank_q  <= '0;
         mask_q   <= '0;
         stb_q    <= 1'b0;
         ill_q    <= 1'b0;
         selerr_q <= 1'b0;
         fd_q     <= 1'b0;
      end else begin
         digits_q <= digits_nxt;
         valid_q  <= valid_nxt;
         blank_q  <= blank_nxt;
         mask_q   <= mask_nxt;
         stb_q    <= stb_nxt;
         ill_q    <= ill_nxt;
         selerr_q <= selerr_nxt;
         fd_q     <= fd_nxt;
      end
   end

   assign bus.digits      = digits_q;
   assign bus.digit_valid = valid_q;
   assign bus.blank       = blank_q;
   assign bus.cap_stb     = stb_q;
   assign bus.illegal     = ill_q;
   assign bus.sel_err     = selerr_q;
   assign bus.frame_done  = fd_q;

endmodule
